// File: rtl/wbu_host_mux_if.sv
// Host-side stream and link signals of the console/devbus link multiplexer.
// The mux takes the slave view; the harness driving the streams takes the master view.
interface wbu_host_mux_if;
  logic       i_bus_stb;
  logic [6:0] i_bus_data;
  logic       o_bus_busy;
  logic       i_con_stb;
  logic [6:0] i_con_data;
  logic       o_con_busy;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic       i_rx_stb;
  logic [7:0] i_rx_data;
  logic       o_bus_stb;
  logic [6:0] o_bus_data;
  logic       i_bus_busy;
  logic       o_con_stb;
  logic [6:0] o_con_data;
  logic       i_con_busy;
  logic [7:0] o_drops;

  modport slave (
    input  i_bus_stb, i_bus_data, i_con_stb, i_con_data, i_tx_busy,
           i_rx_stb, i_rx_data, i_bus_busy, i_con_busy,
    output o_bus_busy, o_con_busy, o_tx_stb, o_tx_data,
           o_bus_stb, o_bus_data, o_con_stb, o_con_data, o_drops
  );

  modport master (
    output i_bus_stb, i_bus_data, i_con_stb, i_con_data, i_tx_busy,
           i_rx_stb, i_rx_data, i_bus_busy, i_con_busy,
    input  o_bus_busy, o_con_busy, o_tx_stb, o_tx_data,
           o_bus_stb, o_bus_data, o_con_stb, o_con_data, o_drops
  );
endinterface

// File: rtl/wbu_host_mux.sv
// Merges host devbus and console byte streams onto one tagged 8-bit link
// (bit 7: 1=bus, 0=console) and splits received link bytes into two FIFOs.

// One receive stream: 2^LGFIFO entry FIFO with drop-on-full reporting.
module wbu_host_mux_fifo #(
  parameter int LGFIFO = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic [6:0] wdata_i,
  input  logic       rd_busy_i,
  output logic       stb_o,
  output logic [6:0] data_o,
  output logic       drop_o
);
  localparam int DEPTH = 1 << LGFIFO;

  logic [LGFIFO:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [6:0]      mem_q [DEPTH];
  logic            empty, full, pop, push;

  assign empty  = (wptr_q == rptr_q);
  assign full   = ((wptr_q ^ rptr_q) == {1'b1, {LGFIFO{1'b0}}});
  assign pop    = !empty && !rd_busy_i;
  // A pop in the same cycle frees the slot the full-FIFO write lands in.
  assign push   = wr_i && (!full || pop);
  assign drop_o = wr_i && full && !pop;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[LGFIFO-1:0]] <= wdata_i;
  end

  assign stb_o  = !empty;
  assign data_o = mem_q[rptr_q[LGFIFO-1:0]];
endmodule

module wbu_host_mux #(
  parameter int LGFIFO = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  wbu_host_mux_if.slave  host_if
);
  localparam int NUM_STREAMS = 2;  // index equals the link tag: 0=console, 1=bus

  typedef enum logic { TX_IDLE, TX_FULL } tx_state_e;
  typedef enum logic { LAST_CON, LAST_BUS } last_e;

  tx_state_e  state_q, state_d;
  last_e      last_q, last_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       bus_busy, con_busy, bus_acc, con_acc;

  // Only one of the two can be granted: the loser of a tie sees busy.
  assign bus_busy = (state_q == TX_FULL) || (host_if.i_con_stb && last_q == LAST_BUS);
  assign con_busy = (state_q == TX_FULL) || (host_if.i_bus_stb && last_q == LAST_CON);
  assign bus_acc  = host_if.i_bus_stb && !bus_busy;
  assign con_acc  = host_if.i_con_stb && !con_busy;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    case (state_q)
      TX_IDLE: begin
        if (bus_acc) begin
          state_d   = TX_FULL;
          tx_data_d = {1'b1, host_if.i_bus_data};
          last_d    = LAST_BUS;
        end else if (con_acc) begin
          state_d   = TX_FULL;
          tx_data_d = {1'b0, host_if.i_con_data};
          last_d    = LAST_CON;
        end
      end
      TX_FULL: begin
        if (!host_if.i_tx_busy) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= TX_IDLE;
      last_q    <= LAST_CON;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign host_if.o_bus_busy = bus_busy;
  assign host_if.o_con_busy = con_busy;
  assign host_if.o_tx_stb   = (state_q == TX_FULL);
  assign host_if.o_tx_data  = tx_data_q;

  logic [NUM_STREAMS-1:0]      rx_wr, rx_busy, rx_stb, rx_drop;
  logic [NUM_STREAMS-1:0][6:0] rx_data;

  assign rx_busy = {host_if.i_bus_busy, host_if.i_con_busy};

  for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_rx
    assign rx_wr[s] = host_if.i_rx_stb && (host_if.i_rx_data[7] == 1'(s));
    wbu_host_mux_fifo #(.LGFIFO(LGFIFO)) u_fifo (
      .clk_i     (i_clk),
      .rst_i     (i_reset),
      .wr_i      (rx_wr[s]),
      .wdata_i   (host_if.i_rx_data[6:0]),
      .rd_busy_i (rx_busy[s]),
      .stb_o     (rx_stb[s]),
      .data_o    (rx_data[s]),
      .drop_o    (rx_drop[s])
    );
  end

  assign host_if.o_bus_stb  = rx_stb[1];
  assign host_if.o_bus_data = rx_data[1];
  assign host_if.o_con_stb  = rx_stb[0];
  assign host_if.o_con_data = rx_data[0];

  logic [7:0] drops_q, drops_d;

  always_comb begin
    drops_d = drops_q;
    if ((|rx_drop) && drops_q != 8'hFF) drops_d = drops_q + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) drops_q <= '0;
    else         drops_q <= drops_d;
  end

  assign host_if.o_drops = drops_q;
endmodule

// File: tb/tb_wbu_host_mux.sv
// Bench for wbu_host_mux: directed scenarios plus a randomized run against a
// queue-based model of the link arbitration and the two receive FIFOs.
module tb_wbu_host_mux;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wbu_host_mux_if h ();
  wbu_host_mux #(.LGFIFO(4)) dut (.i_clk(clk), .i_reset(rst), .host_if(h));

  int checks = 0;
  int errors = 0;

  // model state
  bit         m_full;
  bit [7:0]   m_data;
  bit         m_last_bus;
  bit [6:0]   qb[$];
  bit [6:0]   qc[$];
  int         m_drops;

  task automatic idle();
    h.i_bus_stb = 0; h.i_bus_data = 0; h.i_con_stb = 0; h.i_con_data = 0;
    h.i_tx_busy = 0; h.i_rx_stb = 0; h.i_rx_data = 0;
    h.i_bus_busy = 0; h.i_con_busy = 0;
  endtask

  // Advance the model with the inputs now driven, then cross one clock edge.
  task automatic tick();
    bit bpop, cpop;
    if (rst) begin
      m_full = 0; m_data = 0; m_last_bus = 0; m_drops = 0;
      qb.delete(); qc.delete();
    end else begin
      if (m_full) begin
        if (!h.i_tx_busy) m_full = 0;
      end else if (h.i_bus_stb && (!h.i_con_stb || !m_last_bus)) begin
        m_full = 1; m_data = {1'b1, h.i_bus_data}; m_last_bus = 1;
      end else if (h.i_con_stb) begin
        m_full = 1; m_data = {1'b0, h.i_con_data}; m_last_bus = 0;
      end
      bpop = (qb.size() > 0) && !h.i_bus_busy;
      cpop = (qc.size() > 0) && !h.i_con_busy;
      if (bpop) void'(qb.pop_front());
      if (cpop) void'(qc.pop_front());
      if (h.i_rx_stb) begin
        if (h.i_rx_data[7]) begin
          if (qb.size() < DEPTH) qb.push_back(h.i_rx_data[6:0]);
          else if (m_drops < 255) m_drops++;
        end else begin
          if (qc.size() < DEPTH) qc.push_back(h.i_rx_data[6:0]);
          else if (m_drops < 255) m_drops++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (h.o_tx_stb !== 1'b0) begin errors++; $display("FAIL reset_tx_stb: got %b want 0", h.o_tx_stb); end
    checks++; if (h.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", h.o_tx_data); end
    checks++; if (h.o_bus_stb !== 1'b0 || h.o_con_stb !== 1'b0) begin errors++; $display("FAIL reset_rx_stb: got %b%b want 00", h.o_bus_stb, h.o_con_stb); end
    checks++; if (h.o_drops !== 8'd0) begin errors++; $display("FAIL reset_drops: got %0d want 0", h.o_drops); end
  endtask

  task automatic test_tie();
    int n = 0;
    int c = 0;
    h.i_bus_stb = 1; h.i_con_stb = 1;
    while (n < 8 && c < 40) begin
      h.i_bus_data = 7'($urandom_range(0, 127));
      h.i_con_data = 7'($urandom_range(0, 127));
      #1;
      if (c == 0) begin
        checks++; if (h.o_bus_busy !== 1'b0 || h.o_con_busy !== 1'b1) begin errors++; $display("FAIL tie_first_grant: got bus_busy=%b con_busy=%b want 0 1", h.o_bus_busy, h.o_con_busy); end
      end
      checks++; if (h.o_tx_stb !== m_full) begin errors++; $display("FAIL tie_tx_stb: got %b want %b cycle %0d", h.o_tx_stb, m_full, c); end
      if (h.o_tx_stb) begin
        checks++; if (h.o_tx_data[7] !== ~n[0]) begin errors++; $display("FAIL tie_tag: got %b want %b byte %0d", h.o_tx_data[7], ~n[0], n); end
        checks++; if (h.o_tx_data !== m_data) begin errors++; $display("FAIL tie_data: got %h want %h", h.o_tx_data, m_data); end
        n++;
      end
      tick();
      c++;
    end
    checks++; if (n != 8 || c != 16) begin errors++; $display("FAIL tie_throughput: got %0d bytes in %0d cycles want 8 in 16", n, c); end
    idle();
    tick();
  endtask

  task automatic test_tx_hold();
    idle();
    tick();
    h.i_con_stb = 1; h.i_con_data = 7'h41; h.i_tx_busy = 1;
    #1;
    checks++; if (h.o_con_busy !== 1'b0) begin errors++; $display("FAIL hold_accept: got con_busy=%b want 0", h.o_con_busy); end
    tick();
    h.i_con_stb = 1; h.i_bus_stb = 1; h.i_con_data = 7'h22; h.i_bus_data = 7'h33;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (h.o_tx_stb !== 1'b1 || h.o_tx_data !== 8'h41) begin errors++; $display("FAIL hold_data: got stb=%b data=%h want 1 41 cycle %0d", h.o_tx_stb, h.o_tx_data, i); end
      checks++; if (h.o_bus_busy !== 1'b1 || h.o_con_busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b%b want 11 cycle %0d", h.o_bus_busy, h.o_con_busy, i); end
      tick();
    end
    h.i_tx_busy = 0; h.i_bus_stb = 0; h.i_con_stb = 0;
    #1;
    checks++; if (h.o_tx_stb !== 1'b1 || h.o_tx_data !== 8'h41) begin errors++; $display("FAIL hold_release: got stb=%b data=%h want 1 41", h.o_tx_stb, h.o_tx_data); end
    tick();
    checks++; if (h.o_tx_stb !== 1'b0) begin errors++; $display("FAIL hold_clear: got %b want 0", h.o_tx_stb); end
  endtask

  task automatic test_rx_split();
    idle();
    h.i_rx_stb = 1; h.i_rx_data = 8'hC1;
    tick();
    checks++; if (h.o_bus_stb !== 1'b1 || h.o_bus_data !== 7'h41 || h.o_con_stb !== 1'b0) begin errors++; $display("FAIL split_1: got bus %b %h con %b want 1 41 0", h.o_bus_stb, h.o_bus_data, h.o_con_stb); end
    h.i_rx_data = 8'h42;
    tick();
    checks++; if (h.o_con_stb !== 1'b1 || h.o_con_data !== 7'h42 || h.o_bus_stb !== 1'b0) begin errors++; $display("FAIL split_2: got con %b %h bus %b want 1 42 0", h.o_con_stb, h.o_con_data, h.o_bus_stb); end
    h.i_rx_data = 8'h80;
    tick();
    checks++; if (h.o_bus_stb !== 1'b1 || h.o_bus_data !== 7'h00 || h.o_con_stb !== 1'b0) begin errors++; $display("FAIL split_3: got bus %b %h con %b want 1 00 0", h.o_bus_stb, h.o_bus_data, h.o_con_stb); end
    h.i_rx_stb = 0;
    tick();
    checks++; if (h.o_bus_stb !== 1'b0) begin errors++; $display("FAIL split_empty: got %b want 0", h.o_bus_stb); end
  endtask

  task automatic test_overflow();
    do_reset();
    h.i_con_busy = 1;
    for (int i = 0; i < 18; i++) begin
      h.i_rx_stb = 1; h.i_rx_data = {1'b0, 7'(i)};
      tick();
      checks++; if (h.o_drops !== 8'((i >= 16) ? i - 15 : 0)) begin errors++; $display("FAIL ovf_drops: got %0d want %0d byte %0d", h.o_drops, (i >= 16) ? i - 15 : 0, i); end
    end
    h.i_rx_stb = 0; h.i_con_busy = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (h.o_con_stb !== 1'b1 || h.o_con_data !== 7'(i)) begin errors++; $display("FAIL ovf_order: got %b %h want 1 %h", h.o_con_stb, h.o_con_data, 7'(i)); end
      tick();
    end
    checks++; if (h.o_con_stb !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", h.o_con_stb); end
  endtask

  task automatic test_full_pop();
    bit [6:0] exp[$];
    bit [6:0] v;
    do_reset();
    h.i_con_busy = 1; h.i_rx_stb = 1;
    for (int i = 0; i < 16; i++) begin
      v = 7'($urandom_range(0, 127));
      h.i_rx_data = {1'b0, v}; exp.push_back(v);
      tick();
    end
    h.i_con_busy = 0;
    for (int i = 0; i < 40; i++) begin
      v = 7'($urandom_range(0, 127));
      h.i_rx_data = {1'b0, v};
      #1;
      checks++; if (h.o_con_stb !== 1'b1 || h.o_con_data !== exp[0]) begin errors++; $display("FAIL fullpop_data: got %b %h want 1 %h step %0d", h.o_con_stb, h.o_con_data, exp[0], i); end
      tick();
      void'(exp.pop_front()); exp.push_back(v);
      checks++; if (h.o_drops !== 8'd0) begin errors++; $display("FAIL fullpop_drops: got %0d want 0 step %0d", h.o_drops, i); end
    end
    h.i_con_busy = 1; h.i_rx_data = 8'h7F;
    tick();
    checks++; if (h.o_drops !== 8'd1) begin errors++; $display("FAIL fullpop_still_full: got %0d want 1", h.o_drops); end
    h.i_rx_stb = 0; h.i_con_busy = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (h.o_con_stb !== 1'b1 || h.o_con_data !== exp[i]) begin errors++; $display("FAIL fullpop_drain: got %b %h want 1 %h", h.o_con_stb, h.o_con_data, exp[i]); end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      h.i_bus_stb  = ($urandom_range(0, 2) != 0);
      h.i_con_stb  = ($urandom_range(0, 2) != 0);
      h.i_bus_data = 7'($urandom_range(0, 127));
      h.i_con_data = 7'($urandom_range(0, 127));
      h.i_tx_busy  = ($urandom_range(0, 1) != 0);
      h.i_rx_stb   = ($urandom_range(0, 3) != 0);
      h.i_rx_data  = 8'($urandom_range(0, 255));
      h.i_bus_busy = ($urandom_range(0, 3) != 0);
      h.i_con_busy = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (h.o_tx_stb !== m_full) begin errors++; $display("FAIL rnd_tx_stb: got %b want %b cycle %0d", h.o_tx_stb, m_full, c); end
      if (m_full) begin
        checks++; if (h.o_tx_data !== m_data) begin errors++; $display("FAIL rnd_tx_data: got %h want %h cycle %0d", h.o_tx_data, m_data, c); end
      end
      checks++; if (h.o_bus_busy !== (m_full || (h.i_con_stb && m_last_bus))) begin errors++; $display("FAIL rnd_bus_busy: got %b cycle %0d", h.o_bus_busy, c); end
      checks++; if (h.o_con_busy !== (m_full || (h.i_bus_stb && !m_last_bus))) begin errors++; $display("FAIL rnd_con_busy: got %b cycle %0d", h.o_con_busy, c); end
      checks++; if (h.o_bus_stb !== (qb.size() > 0)) begin errors++; $display("FAIL rnd_bus_stb: got %b want %b cycle %0d", h.o_bus_stb, qb.size() > 0, c); end
      if (qb.size() > 0) begin
        checks++; if (h.o_bus_data !== qb[0]) begin errors++; $display("FAIL rnd_bus_data: got %h want %h cycle %0d", h.o_bus_data, qb[0], c); end
      end
      checks++; if (h.o_con_stb !== (qc.size() > 0)) begin errors++; $display("FAIL rnd_con_stb: got %b want %b cycle %0d", h.o_con_stb, qc.size() > 0, c); end
      if (qc.size() > 0) begin
        checks++; if (h.o_con_data !== qc[0]) begin errors++; $display("FAIL rnd_con_data: got %h want %h cycle %0d", h.o_con_data, qc[0], c); end
      end
      checks++; if (h.o_drops !== 8'(m_drops)) begin errors++; $display("FAIL rnd_drops: got %0d want %0d cycle %0d", h.o_drops, m_drops, c); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    h.i_con_busy = 1; h.i_bus_busy = 1; h.i_rx_stb = 1;
    for (int i = 0; i < 20; i++) begin
      h.i_rx_data = {1'b0, 7'(i)};
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      h.i_rx_data = {1'b1, 7'(i)};
      tick();
    end
    h.i_rx_stb = 0; h.i_con_stb = 1; h.i_con_data = 7'h55; h.i_tx_busy = 1;
    tick();
    h.i_con_stb = 0;
    #1;
    checks++; if (h.o_tx_stb !== 1'b1 || h.o_drops !== 8'd4 || h.o_bus_stb !== 1'b1) begin errors++; $display("FAIL mid_setup: got tx %b drops %0d bus %b want 1 4 1", h.o_tx_stb, h.o_drops, h.o_bus_stb); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (h.o_tx_stb !== 1'b0 || h.o_bus_stb !== 1'b0 || h.o_con_stb !== 1'b0) begin errors++; $display("FAIL mid_stbs: got %b%b%b want 000", h.o_tx_stb, h.o_bus_stb, h.o_con_stb); end
    checks++; if (h.o_drops !== 8'd0) begin errors++; $display("FAIL mid_drops: got %0d want 0", h.o_drops); end
    idle();
    h.i_bus_stb = 1; h.i_con_stb = 1; h.i_bus_data = 7'h12; h.i_con_data = 7'h34;
    #1;
    checks++; if (h.o_bus_busy !== 1'b0 || h.o_con_busy !== 1'b1) begin errors++; $display("FAIL mid_tie: got %b%b want 01", h.o_bus_busy, h.o_con_busy); end
    tick();
    checks++; if (h.o_tx_stb !== 1'b1 || h.o_tx_data !== 8'h92) begin errors++; $display("FAIL mid_grant: got %b %h want 1 92", h.o_tx_stb, h.o_tx_data); end
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_tie();
    test_tx_hold();
    test_rx_split();
    test_overflow();
    test_full_pop();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
